// File: rtl/counter_pkg.sv
// counter_pkg: shared types, default parameters and load clamp helper for counter_mod_ud
package counter_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} cnt_dir_t;
  localparam int CNT_WIDTH = 8;
  localparam int CNT_DEFAULT_N = 5;
  localparam int CNT_WRAP_BITS = 4;
  function automatic logic [31:0] clamp_to_last(input logic [31:0] d, input logic [31:0] last);
    return d > last ? last : d;
  endfunction
endpackage

// File: rtl/counter_mod_ud_wrap_tally.sv
// wrap_tally: counts wraps with a sticky rollover flag; clear beats a simultaneous increment
module wrap_tally #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            r_n,
  input  logic            inc,
  input  logic            clr,
  output logic [BITS-1:0] cnt,
  output logic            ovf
);
  always_ff @(posedge clk)
    if (!r_n || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
      ovf <= ovf || &cnt;
    end
endmodule

// File: rtl/counter_mod_ud.sv
// counter_mod_ud: up/down modulo-N counter with shadowed modulus and wrap tally; parallel load enabled by COUNTER_MOD_UD_LOAD_EN
module counter_mod_ud
  import counter_pkg::*;
#(
  parameter int WIDTH     = CNT_WIDTH,
  parameter int DEFAULT_N = CNT_DEFAULT_N,
  parameter int WRAP_BITS = CNT_WRAP_BITS
) (
  input  logic                 clk,
  input  logic                 r_n,
  input  logic                 en,
  input  logic                 up,
  input  logic                 mod_wr,
  input  logic [WIDTH-1:0]     mod_last,
  input  logic                 ld,
  input  logic [WIDTH-1:0]     d,
  input  logic                 wrap_clr,
  output logic [WIDTH-1:0]     q,
  output logic                 co,
  output logic [WIDTH-1:0]     n_last,
  output logic                 mod_pend,
  output logic [WRAP_BITS-1:0] wrap_cnt,
  output logic                 wrap_ovf
);
  localparam logic [WIDTH-1:0] RST_LAST = WIDTH'(DEFAULT_N - 1);
  cnt_dir_t dir;
  logic ld_eff, term, apply;
  logic [WIDTH-1:0] pend_last, last_next, q_step, q_load;
`ifdef COUNTER_MOD_UD_LOAD_EN
  assign ld_eff = ld;
`else
  logic unused_load;
  assign ld_eff = 1'b0;
  assign unused_load = ld;
`endif
  assign dir = cnt_dir_t'(up);
  assign term = dir == DIR_UP ? q == n_last : q == '0;
  assign co = en && term && !ld_eff;
  assign apply = co || ld_eff;
  // modulus only changes on a wrap or load edge, so q never sits above n_last
  assign last_next = !apply ? n_last : mod_wr ? mod_last : mod_pend ? pend_last : n_last;
  assign q_step = dir == DIR_UP ? (term ? '0 : q + 1'b1) : (term ? last_next : q - 1'b1);
  assign q_load = WIDTH'(clamp_to_last(32'(d), 32'(last_next)));
  always_ff @(posedge clk)
    if (!r_n) begin
      q         <= '0;
      n_last    <= RST_LAST;
      pend_last <= RST_LAST;
      mod_pend  <= 1'b0;
    end else begin
      q         <= ld_eff ? q_load : en ? q_step : q;
      n_last    <= last_next;
      pend_last <= mod_wr ? mod_last : pend_last;
      mod_pend  <= !apply && (mod_wr || mod_pend);
    end
  wrap_tally #(.BITS(WRAP_BITS)) u_tally (
    .clk(clk),
    .r_n(r_n),
    .inc(co),
    .clr(wrap_clr),
    .cnt(wrap_cnt),
    .ovf(wrap_ovf)
  );
endmodule

// File: tb/tb_counter_mod_ud.sv
// tb_counter_mod_ud: directed plan plus random traffic checked against an arithmetic modulo-N model
module tb_counter_mod_ud;
`ifdef COUNTER_MOD_UD_LOAD_EN
  localparam bit LOAD = 1'b1;
`else
  localparam bit LOAD = 1'b0;
`endif
  logic clk = 1'b0, r_n, en, up, mod_wr, ld, wrap_clr, co, mod_pend, wrap_ovf;
  logic [7:0] mod_last, d, q, n_last;
  logic [3:0] wrap_cnt;
  int ncmp = 0, nfail = 0;
  int m_q, m_last, m_pval, m_pend, m_wraps;

  always #5 clk = ~clk;

  counter_mod_ud dut (
    .clk(clk), .r_n(r_n), .en(en), .up(up), .mod_wr(mod_wr), .mod_last(mod_last),
    .ld(ld), .d(d), .wrap_clr(wrap_clr), .q(q), .co(co), .n_last(n_last),
    .mod_pend(mod_pend), .wrap_cnt(wrap_cnt), .wrap_ovf(wrap_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_last = 4; m_pval = 4; m_pend = 0; m_wraps = 0;
  endtask

  task automatic check_regs();
    chk("q", {24'd0, q}, m_q);
    chk("n_last", {24'd0, n_last}, m_last);
    chk("mod_pend", {31'd0, mod_pend}, m_pend);
    chk("wrap_cnt", {28'd0, wrap_cnt}, m_wraps % 16);
    chk("wrap_ovf", {31'd0, wrap_ovf}, m_wraps >= 16);
  endtask

  task automatic step(input bit rn, input bit en_i, input bit up_i, input bit wr, input int ml,
                      input bit ld_i, input int d_i, input bit clr);
    int n, nl;
    bit le, tm, c, ap;
    @(negedge clk);
    r_n = rn; en = en_i; up = up_i; mod_wr = wr; mod_last = 8'(ml);
    ld = ld_i; d = 8'(d_i); wrap_clr = clr;
    le = LOAD && ld_i;
    tm = up_i ? m_q == m_last : m_q == 0;
    c = en_i && tm && !le;
    #1 chk("co", {31'd0, co}, c);
    ap = c || le;
    nl = !ap ? m_last : wr ? ml : m_pend ? m_pval : m_last;
    n = m_last + 1;
    @(posedge clk);
    if (!rn) model_reset();
    else begin
      if (le) m_q = d_i < nl ? d_i : nl;
      else if (c) m_q = up_i ? 0 : nl;
      else if (en_i) m_q = (m_q + (up_i ? 1 : n - 1)) % n;
      m_wraps = clr ? 0 : m_wraps + c;
      if (wr) m_pval = ml;
      m_pend = !ap && (wr || m_pend);
      m_last = nl;
    end
    #1 check_regs();
  endtask

  task automatic run(input int k, input bit up_i);
    repeat (k) step(1, 1, up_i, 0, 0, 0, 0, 0);
  endtask

  initial begin
    r_n = 0; en = 0; up = 0; mod_wr = 0; mod_last = 0; ld = 0; d = 0; wrap_clr = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 check_regs();
    chk("rst_n_last", {24'd0, n_last}, 4);
    // default N = 5 counting up
    run(12, 1);
    chk("up_wraps", {28'd0, wrap_cnt}, 2);
    chk("up_q", {24'd0, q}, 2);
    // counting down from 0
    step(0, 0, 0, 0, 0, 0, 0, 0);
    run(6, 0);
    chk("down_q", {24'd0, q}, 4);
    // modulus shadow applied on wrap
    step(0, 0, 0, 0, 0, 0, 0, 0);
    run(2, 1);
    step(1, 1, 1, 1, 2, 0, 0, 0);
    chk("pend_set", {31'd0, mod_pend}, 1);
    chk("pend_old_last", {24'd0, n_last}, 4);
    run(2, 1);
    chk("new_last", {24'd0, n_last}, 2);
    run(3, 1);
    chk("short_q", {24'd0, q}, 0);
    // load behaviour
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1, 200, 0);
`ifdef COUNTER_MOD_UD_LOAD_EN
    chk("ld_clamp", {24'd0, q}, 4);
`else
    chk("ld_ignored", {24'd0, q}, 0);
`endif
    step(1, 1, 1, 0, 0, 1, 1, 0);
    // N = 1 drives the wrap counter to overflow
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    run(4, 1);
    chk("n1_last", {24'd0, n_last}, 0);
    step(1, 0, 1, 0, 0, 0, 0, 1);
    run(16, 1);
    chk("ovf_cnt", {28'd0, wrap_cnt}, 0);
    chk("ovf_flag", {31'd0, wrap_ovf}, 1);
    step(1, 1, 1, 0, 0, 0, 0, 1);
    chk("clr_flag", {31'd0, wrap_ovf}, 0);
    // reset mid-count with a pending modulus
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 6, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_q", {24'd0, q}, 3);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("rst_q", {24'd0, q}, 0);
    chk("rst_pend", {31'd0, mod_pend}, 0);
    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9),
           $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0 ? 200 : $urandom_range(0, 15),
           $urandom_range(0, 29) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
